// File: rtl/uart_calc_ctrl_if.sv
// uart_calc_ctrl_if
// Byte-stream handshake bundle between the UART receiver/transmitter and the
// division controller.
//   rx_valid / rx_data : received byte strobe and value
//   tx_ready           : transmitter can accept a byte
//   tx_valid / tx_data : byte offered to the transmitter
//   busy / err         : frame in progress / last frame had divisor zero
// Modports: slave = controller side, master = UART / environment side.
interface uart_calc_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic       err;

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, busy, err
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, busy, err
  );
endinterface

// File: rtl/uart_calc_ctrl.sv
// uart_calc_ctrl
// Collects two DATA_W-bit operands (A then B, MSB first) from received bytes,
// runs a restoring division one quotient bit per clock, then streams the
// quotient and remainder (MSB first) out through a valid/ready handshake.
// Divisor zero skips the iterations: quotient = all ones, remainder = A, err=1.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : uart_calc_ctrl_if.slave (rx_valid, rx_data, tx_ready in;
//          tx_valid, tx_data, busy, err out)
// Optional feature macro: CALC_STATUS_EN -- when defined, a status byte
// (8'h00 normal, 8'hEE divisor zero) is sent before the results.
module uart_calc_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_calc_ctrl_if.slave   bus
);

  localparam int NB = DATA_W / 8;
`ifdef CALC_STATUS_EN
  localparam int TX_OFS = 1;
`else
  localparam int TX_OFS = 0;
`endif
  localparam int TX_LEN = 2 * NB + TX_OFS;
  localparam int IDX_W  = $clog2(2 * NB + 2);
  localparam int ITER_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_RX  = 2'd0,
    S_DIV = 2'd1,
    S_TX  = 2'd2
  } state_t;

  state_t                state_r;
  logic [DATA_W-1:0]     a_r;
  logic [DATA_W-1:0]     b_r;
  logic [2*DATA_W-1:0]   rq_r;
  logic [DATA_W-1:0]     quot_r;
  logic [DATA_W-1:0]     rem_r;
  logic [IDX_W-1:0]      byte_idx_r;
  logic [ITER_W-1:0]     iter_r;
  logic                  tx_valid_r;
  logic [7:0]            tx_data_r;
  logic                  busy_r;
  logic                  err_r;

  logic [DATA_W:0]       trial_s;
  logic [2*DATA_W-1:0]   rq_next_s;

  // Byte k (MSB first) of the concatenated {quotient, remainder} result.
  function automatic logic [7:0] pick_byte(input logic [2*DATA_W-1:0] res,
                                           input logic [IDX_W-1:0]    k);
    logic [2*DATA_W-1:0] sh;
    sh = res >> (8 * (2 * NB - 1 - int'(k)));
    return sh[7:0];
  endfunction

  // One restoring-division step on the shifted {R,Q}; the subtraction is one
  // bit wider than R so its top bit is a clean borrow flag.
  always_comb begin
    trial_s   = rq_r[2*DATA_W-1:DATA_W-1] - {1'b0, b_r};
    rq_next_s = {rq_r[2*DATA_W-2:0], 1'b0};
    if (!trial_s[DATA_W]) begin
      rq_next_s = {trial_s[DATA_W-1:0], rq_r[DATA_W-2:0], 1'b1};
    end else begin
      rq_next_s = {rq_r[2*DATA_W-2:0], 1'b0};
    end
  end

  // Frame FSM: operand capture, division iterations, result streaming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_RX;
      a_r        <= '0;
      b_r        <= '0;
      rq_r       <= '0;
      quot_r     <= '0;
      rem_r      <= '0;
      byte_idx_r <= '0;
      iter_r     <= '0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        S_RX: begin
          if (bus.rx_valid) begin
            if (byte_idx_r == '0) begin
              busy_r <= 1'b1;
              err_r  <= 1'b0;
            end
            if (byte_idx_r < IDX_W'(NB)) begin
              a_r <= (a_r << 8) | DATA_W'(bus.rx_data);
            end else begin
              b_r <= (b_r << 8) | DATA_W'(bus.rx_data);
            end
            if (byte_idx_r == IDX_W'(2 * NB - 1)) begin
              // A is already complete here; B lands on this same edge.
              state_r    <= S_DIV;
              byte_idx_r <= '0;
              iter_r     <= '0;
              rq_r       <= {{DATA_W{1'b0}}, a_r};
            end else begin
              byte_idx_r <= byte_idx_r + IDX_W'(1);
            end
          end
        end
        S_DIV: begin
          if (b_r == '0) begin
            quot_r     <= {DATA_W{1'b1}};
            rem_r      <= a_r;
            err_r      <= 1'b1;
            tx_valid_r <= 1'b1;
            state_r    <= S_TX;
`ifdef CALC_STATUS_EN
            tx_data_r  <= 8'hEE;
`else
            tx_data_r  <= 8'hFF;
`endif
          end else if (iter_r == ITER_W'(DATA_W - 1)) begin
            // Final step: latch results straight from the step logic so the
            // first byte is offered on the next cycle.
            quot_r     <= rq_next_s[DATA_W-1:0];
            rem_r      <= rq_next_s[2*DATA_W-1:DATA_W];
            tx_valid_r <= 1'b1;
            state_r    <= S_TX;
`ifdef CALC_STATUS_EN
            tx_data_r  <= 8'h00;
`else
            tx_data_r  <= rq_next_s[DATA_W-1 -: 8];
`endif
          end else begin
            rq_r   <= rq_next_s;
            iter_r <= iter_r + ITER_W'(1);
          end
        end
        S_TX: begin
          if (tx_valid_r && bus.tx_ready) begin
            if (byte_idx_r == IDX_W'(TX_LEN - 1)) begin
              tx_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              byte_idx_r <= '0;
              state_r    <= S_RX;
            end else begin
              byte_idx_r <= byte_idx_r + IDX_W'(1);
              tx_data_r  <= pick_byte({quot_r, rem_r},
                                      byte_idx_r + IDX_W'(1) - IDX_W'(TX_OFS));
            end
          end
        end
        default: begin
          state_r <= S_RX;
        end
      endcase
    end
  end

  assign bus.tx_valid = tx_valid_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.busy     = busy_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_uart_calc_ctrl.sv
// tb_uart_calc_ctrl
// Table-driven directed bench for uart_calc_ctrl: one DATA_W=16 and one
// DATA_W=32 instance, each vector gives rx bytes, expected tx bytes, err,
// first-tx latency and an optional transmit stall. Hand-written sequences
// cover asynchronous reset mid-division and partial-frame discard.
module tb_uart_calc_ctrl;

`ifdef CALC_STATUS_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  typedef struct {
    int         w;
    logic [7:0] rx [8];
    logic [7:0] tx [8];
    logic       err;
    int         lat;
    int         stall;
    logic       inject;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_calc_ctrl_if b16();
  uart_calc_ctrl_if b32();

  uart_calc_ctrl #(.DATA_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  uart_calc_ctrl #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int w, input logic v, input logic [7:0] d, input logic r);
    if (w == 32) begin
      b32.rx_valid = v; b32.rx_data = d; b32.tx_ready = r;
    end else begin
      b16.rx_valid = v; b16.rx_data = d; b16.tx_ready = r;
    end
  endtask

  // {busy, err, tx_valid, tx_data}
  function automatic logic [10:0] smp(input int w);
    if (w == 32) return {b32.busy, b32.err, b32.tx_valid, b32.tx_data};
    else         return {b16.busy, b16.err, b16.tx_valid, b16.tx_data};
  endfunction

  task automatic run_frame(input vec_t v);
    int          nb, ntx, n;
    logic        rdy, seen;
    logic [10:0] s;
    logic [7:0]  exp_b [9];
    nb  = v.w / 8;
    ntx = 2 * nb + STAT;
    for (int k = 0; k < 9; k++) exp_b[k] = 8'h00;
    if (STAT == 1) begin
      exp_b[0] = v.err ? 8'hEE : 8'h00;
      for (int k = 0; k < 2 * nb; k++) exp_b[k+1] = v.tx[k];
    end else begin
      for (int k = 0; k < 2 * nb; k++) exp_b[k] = v.tx[k];
    end
    rdy = (v.stall == 0);
    for (int i = 0; i < 2 * nb; i++) begin
      @(negedge clk);
      drv(v.w, 1'b1, v.rx[i], rdy);
      if (i != 2 * nb - 1) begin
        @(negedge clk);
        drv(v.w, 1'b0, 8'h00, rdy);
      end
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      s = smp(v.w);
      if (s[8]) seen = 1'b1;
      drv(v.w, v.inject & n[0], 8'h77, rdy);
    end
    chk("first_tx_latency", 32'(n), 32'(v.lat));
    if (!seen) begin
      drv(v.w, 1'b0, 8'h00, 1'b1);
      return;
    end
    chk("busy_during_frame", 32'(s[10]), 32'd1);
    for (int i = 0; i < v.stall; i++) begin
      s = smp(v.w);
      chk("stall_hold", {23'd0, s[8:0]}, {23'd0, 1'b1, exp_b[0]});
      drv(v.w, v.inject, 8'h99, 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < ntx; k++) begin
      s = smp(v.w);
      chk("tx_byte", {23'd0, s[8:0]}, {23'd0, 1'b1, exp_b[k]});
      drv(v.w, v.inject && (k != ntx - 1), 8'h5A, 1'b1);
      @(negedge clk);
    end
    drv(v.w, 1'b0, 8'h00, 1'b1);
    s = smp(v.w);
    chk("busy_after_frame", 32'(s[10]), 32'd0);
    chk("tx_valid_after_frame", 32'(s[8]), 32'd0);
    chk("err_flag", 32'(s[9]), 32'(v.err));
  endtask

  vec_t        vecs [7];
  int          order [6] = '{0, 1, 2, 4, 3, 6};
  logic [10:0] s;

  initial begin
    vecs[0] = '{w:16, rx:'{8'h12,8'h34,8'h00,8'h10,8'h00,8'h00,8'h00,8'h00},
                tx:'{8'h01,8'h23,8'h00,8'h04,8'h00,8'h00,8'h00,8'h00},
                err:1'b0, lat:17, stall:0, inject:1'b0};
    vecs[1] = '{w:16, rx:'{8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                tx:'{8'hFF,8'hFF,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00},
                err:1'b1, lat:2, stall:0, inject:1'b0};
    vecs[2] = '{w:16, rx:'{8'h00,8'h05,8'h00,8'h07,8'h00,8'h00,8'h00,8'h00},
                tx:'{8'h00,8'h00,8'h00,8'h05,8'h00,8'h00,8'h00,8'h00},
                err:1'b0, lat:17, stall:10, inject:1'b1};
    vecs[3] = '{w:32, rx:'{8'hFF,8'hFF,8'hFF,8'hFF,8'h00,8'h00,8'h00,8'h03},
                tx:'{8'h55,8'h55,8'h55,8'h55,8'h00,8'h00,8'h00,8'h00},
                err:1'b0, lat:33, stall:0, inject:1'b0};
    vecs[4] = '{w:16, rx:'{8'h12,8'h34,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                tx:'{8'hFF,8'hFF,8'h12,8'h34,8'h00,8'h00,8'h00,8'h00},
                err:1'b1, lat:2, stall:0, inject:1'b0};
    vecs[5] = '{w:16, rx:'{8'h00,8'h64,8'h00,8'h0A,8'h00,8'h00,8'h00,8'h00},
                tx:'{8'h00,8'h0A,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                err:1'b0, lat:17, stall:0, inject:1'b0};
    vecs[6] = '{w:32, rx:'{8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h07},
                tx:'{8'h00,8'h00,8'h00,8'h24,8'h00,8'h00,8'h00,8'h04},
                err:1'b0, lat:33, stall:0, inject:1'b0};

    drv(16, 1'b0, 8'h00, 1'b1);
    drv(32, 1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs_16", 32'(smp(16)), 32'd0);
    chk("reset_outputs_32", 32'(smp(32)), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[order[i]]);
      repeat (2) @(negedge clk);
    end

    // Reset during division iteration 5 of 100/10.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv(16, 1'b1, vecs[5].rx[i], 1'b1);
      if (i != 3) begin
        @(negedge clk);
        drv(16, 1'b0, 8'h00, 1'b1);
      end
    end
    repeat (6) @(negedge clk);
    drv(16, 1'b0, 8'h00, 1'b1);
    s = smp(16);
    chk("busy_in_div", 32'(s[10]), 32'd1);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", 32'(smp(16)), 32'd0);
    @(negedge clk);
    chk("held_reset_outputs", 32'(smp(16)), 32'd0);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("no_result_after_reset", 32'(smp(16)), 32'd0);

    // Partial frame (two bytes) discarded by reset.
    @(negedge clk); drv(16, 1'b1, 8'hAB, 1'b1);
    @(negedge clk); drv(16, 1'b1, 8'hCD, 1'b1);
    @(negedge clk); drv(16, 1'b0, 8'h00, 1'b1);
    s = smp(16);
    chk("busy_partial", 32'(s[10]), 32'd1);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(vecs[5]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_calc_ctrl.md
# uart_calc_ctrl

Parametrised byte-stream arithmetic controller between the UART receiver and transmitter. It collects two DATA_W-bit operands from received bytes, MSB first, and runs a restoring division, one bit per clock. It then streams the quotient and remainder back out byte by byte through a valid/ready handshake. It replaces the fixed 16-bit, timer-paced controller: operand width is generic, the transmit side is flow-controlled, and divide-by-zero is defined and flagged.

## Interface
- DATA_W, 16, operand/result width in bits; multiple of 8, range 8..32
- NB (localparam), DATA_W/8, bytes per operand/result
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- rx_valid  input  1  one-cycle pulse: rx_data holds a newly received byte
- rx_data  input  8  received byte
- tx_ready  input  1  transmitter can accept a byte this cycle
- tx_valid  output  1  tx_data holds a byte to send
- tx_data  output  8  byte to send
- busy  output  1  frame in progress (first byte received through last byte sent)
- err  output  1  last frame had divisor zero

## Operation
- States: S_RX, S_DIV, S_TX. Reset state is S_RX.
- S_RX:
  - Each rx_valid stores rx_data into A for byte indices 0..NB-1, then into B for indices NB..2NB-1, MSB first.
  - The first byte of a frame sets busy=1 and clears err.
  - The byte at index 2NB-1 moves the FSM to S_DIV.
- S_DIV: restoring division over DATA_W iterations.
  - Working register {R,Q} is 2*DATA_W bits wide and is initialised to {0,A}.
  - Each cycle: shift left 1. If R >= B, then R = R - B and Q[0] = 1.
  - Comparison and subtraction are done at DATA_W+1 bits, so no overflow.
  - After DATA_W iterations, latch quotient=Q and remainder=R, then go to S_TX.
- B==0: no iteration is performed. Quotient = all ones, remainder = A, err=1. Still transmitted normally.
- S_TX: sends quotient bytes MSB first, then remainder bytes MSB first (2NB bytes).
  - The byte is consumed on the cycle where tx_valid && tx_ready.
  - After the last byte is consumed: go to S_RX, busy=0.
- rx_valid pulses arriving in S_DIV or S_TX are dropped; they do not start a new frame.
- Byte index counter resets to 0 when a frame completes.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, busy=0, err=0. A, B, quotient, remainder and all counters are 0.
- rx_valid for the last B byte at cycle t:
  - S_DIV runs cycles t+1..t+DATA_W.
  - tx_valid=1 with the first byte from cycle t+DATA_W+1.
- Divide-by-zero: tx_valid rises at t+2.
- tx_valid and tx_data change only at reset or on the cycle after a handshake. While tx_ready=0, they hold stable with no limit.
- Back-to-back: with tx_ready held 1, one byte is consumed per cycle. tx_valid stays high across the 2NB bytes.
- busy falls in the cycle after the final handshake. A new frame's first byte is accepted from that cycle.
- Asynchronous reset in any state returns all outputs and registers to reset values immediately. A partially received frame is discarded.

## Configuration
- CALC_STATUS_EN defined: a status byte precedes the results, so 2NB+1 bytes are sent per frame.
  - Status byte is 8'h00 for normal, 8'hEE for divisor zero.
  - The first tx_valid timing is unchanged; the status byte is simply the first byte.
- CALC_STATUS_EN undefined: exactly 2NB bytes are sent. err is the only zero indication.

## Test plan
- DATA_W=16, rx bytes 12 34 00 10 (4660/16), tx_ready=1 -> tx 01 23 00 04, err=0, busy low after 4th handshake.
- DATA_W=16, rx 00 FF 00 00 -> tx FF FF 00 FF, err=1, first tx_valid 2 cycles after last rx byte.
- DATA_W=16, rx 00 05 00 07 (A<B) with tx_ready low for 10 cycles after tx_valid rises -> tx_data holds 8'h00 stable throughout; stream 00 00 00 05.
- DATA_W=32, rx FF FF FF FF 00 00 00 03 -> tx 55 55 55 55 00 00 00 00; first tx_valid exactly 33 cycles after last rx byte.
- Reset asserted at S_DIV iteration 5, then new frame 00 64 00 0A -> outputs at reset values during reset, then tx 00 0A 00 00. Extra rx_valid pulses during S_TX -> ignored, next frame parses correctly.
- CALC_STATUS_EN, DATA_W=16, rx 12 34 00 00 -> tx EE FF FF 12 34, err=1.
